// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I control path: opcodes, FSM states
// and the select encodings consumed by the datapath muxes and ALU decoder.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-format select, decoded purely from the opcode so the immediate is
// ready in every state (DECODE needs the B/J immediate for the branch target).
module imm_src_dec
  import riscv_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core with req/ready memory handshake
// and sticky illegal-opcode detection; state is exported for observation.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal,
  output logic       instr_done,
  output state_t     state
);

  // Memory handshake: mem_req with mem_write/adr_src stays stable until a cycle
  // with mem_ready=1, which completes the access; that cycle is the last one.
  state_t state_q, state_d;
  logic   illegal_q, illegal_set;
  logic   mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c, done_c;

  imm_src_dec u_imm_src_dec (
    .op      (op),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | illegal_set;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    alu_op      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BEQ;
          default: begin
            illegal_set = 1'b1;
            if (ILLEGAL_HALT) begin
              state_d = S_HALT;
            end else begin
              state_d = S_FETCH;
              done_c  = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src     = 1'b1;
        done_c      = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_JAL: begin
        // Return address PC+4 is formed from OldPC while the jump target
        // computed in DECODE (held in ALUOut) is loaded into the PC.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_op     = ALUOP_SUB;
        pc_write_c = zero;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is held, even though FETCH is decoded.
  assign mem_req    = mem_req_c & resetn;
  assign mem_write  = mem_write_c & resetn;
  assign ir_write   = ir_write_c & resetn;
  assign pc_write   = pc_write_c & resetn;
  assign reg_write  = reg_write_c & resetn;
  assign instr_done = done_c & resetn;
  assign illegal    = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle hand-computed expectations for
// each instruction class, wait states, illegal-op halt and asynchronous reset.
module tb_multicycle_ctrl;
  import riscv_pkg::*;

  logic       clk;
  logic       resetn;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic       illegal, instr_done;
  state_t     state;

  int n_cmp;
  int n_bad;
  logic [3:0] exp_q[$];
  logic [3:0] exp_s;
  int cnt_a, cnt_b, cnt_c;

  multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .illegal    (illegal),
    .instr_done (instr_done),
    .state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic lw_rdy[10];
    logic sw_rdy[5];
    n_cmp = 0;
    n_bad = 0;
    resetn = 1'b0;
    op = OP_RTYPE;
    zero = 1'b0;
    mem_ready = 1'b1;
    next_cycle();
    next_cycle();

    // held in reset: strobes low, selects at FETCH values
    #1;
    check_eq("rst_state", state, S_FETCH);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_ir_write", ir_write, 0);
    check_eq("rst_pc_write", pc_write, 0);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_alu_src_b", alu_src_b, 2'b10);
    check_eq("rst_result_src", result_src, 2'b10);
    resetn = 1'b1;

    // R-type, no wait states
    exp_q = {S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_s = exp_q.pop_front();
      check_eq("r_state", state, exp_s);
      check_eq("r_reg_write", reg_write, (i == 3));
      cnt_a += instr_done;
      if (i == 2) check_eq("r_alu_op", alu_op, 2'b10);
      next_cycle();
    end
    check_eq("r_done_cnt", cnt_a, 1);
    check_eq("r_back_fetch", state, S_FETCH);

    // lw with 2 FETCH wait states and 3 MEMREAD wait states
    op = OP_LOAD;
    lw_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 10; i++) begin
      mem_ready = lw_rdy[i];
      #1;
      cnt_a += ir_write;
      cnt_b += reg_write;
      if (i == 0) check_eq("lw_wait_pc", pc_write, 0);
      if (i == 2) check_eq("lw_ir_write", ir_write, 1);
      if (i == 5) check_eq("lw_memread", {state, mem_req, adr_src}, {S_MEMREAD, 2'b11});
      if (i == 9) check_eq("lw_wb", {state, reg_write, result_src, instr_done}, {S_MEMWB, 1'b1, 2'b01, 1'b1});
      next_cycle();
    end
    check_eq("lw_ir_cnt", cnt_a, 1);
    check_eq("lw_regwr_cnt", cnt_b, 1);

    // sw with one wait state in MEMWRITE
    op = OP_STORE;
    sw_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = sw_rdy[i];
      #1;
      cnt_a += instr_done;
      cnt_b += reg_write;
      if (i == 0) check_eq("sw_imm_src", imm_src, 2'b01);
      if (i >= 3) check_eq("sw_memwrite", {state, mem_req, mem_write, adr_src}, {S_MEMWRITE, 3'b111});
      if (i == 4) check_eq("sw_done", instr_done, 1);
      next_cycle();
    end
    check_eq("sw_done_cnt", cnt_a, 1);
    check_eq("sw_regwr_cnt", cnt_b, 0);
    check_eq("sw_back_fetch", state, S_FETCH);

    // beq taken then not taken
    op = OP_BRANCH;
    mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      for (int i = 0; i < 3; i++) begin
        #1;
        if (i == 1) check_eq("beq_imm_src", imm_src, 2'b10);
        if (i == 2) check_eq("beq_cycle", {state, pc_write, instr_done, alu_op}, {S_BEQ, z[0], 1'b1, 2'b01});
        next_cycle();
      end
      check_eq("beq_back_fetch", state, S_FETCH);
    end
    zero = 1'b0;

    // jal
    op = OP_JAL;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 2) check_eq("jal_cycle", {state, pc_write, alu_src_a, alu_src_b, imm_src}, {S_JAL, 1'b1, 2'b01, 2'b10, 2'b11});
      if (i == 3) check_eq("jal_wb", {state, reg_write, instr_done}, {S_ALUWB, 2'b11});
      next_cycle();
    end

    // I-type ALU
    op = OP_ITYPE;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 2) check_eq("execi", {state, alu_src_a, alu_src_b, alu_op}, {S_EXECI, 2'b10, 2'b01, 2'b10});
      next_cycle();
    end
    check_eq("i_back_fetch", state, S_FETCH);

    // illegal opcode halts; reset clears
    op = 7'b1111111;
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i == 1) check_eq("ill_decode", {state, illegal, imm_src}, {S_DECODE, 1'b0, 2'b00});
      if (i >= 2) begin
        check_eq("ill_halt", {state, illegal}, {S_HALT, 1'b1});
        cnt_a += mem_req;
      end
      next_cycle();
    end
    check_eq("ill_no_req", cnt_a, 0);
    resetn = 1'b0;
    #1;
    check_eq("ill_rst", {state, illegal, mem_req}, {S_FETCH, 2'b00});
    next_cycle();
    resetn = 1'b1;
    #1;
    check_eq("ill_release", {state, mem_req, adr_src}, {S_FETCH, 2'b10});

    // reset asserted mid-MEMREAD with mem_ready low
    op = OP_LOAD;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      next_cycle();
    end
    mem_ready = 1'b0;
    #1;
    check_eq("mr_pre", {state, mem_req, adr_src}, {S_MEMREAD, 2'b11});
    #2;
    resetn = 1'b0;
    #1;
    check_eq("mr_async", {state, mem_req, mem_write, ir_write, reg_write, adr_src}, {S_FETCH, 5'b00000});
    next_cycle();
    resetn = 1'b1;
    #1;
    check_eq("mr_release", {state, mem_req, adr_src}, {S_FETCH, 2'b10});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core. It sequences one shared ALU, one unified instruction/data memory port, the register file, and the PC/IR/ALUOut/Data registers through per-instruction steps.
- Covers lw, sw, R-type, I-type ALU, beq and jal.
- Adds a req/ready memory handshake and sticky illegal-opcode detection.
- Feeds ALUOp to the existing ALU decoder, which it does not replace.

Parameters:
ILLEGAL_HALT, 1, 1: an unknown opcode enters HALT permanently; 0: the instruction is skipped and control returns to FETCH.

Ports:
clk  in  1  system clock, all state updates on the rising edge
resetn  in  1  asynchronous active-low reset
op  in  7  instr[6:0] from the IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access in progress
mem_write  out  1  store strobe; asserted only when mem_req is asserted
adr_src  out  1  0 = PC, 1 = Result
ir_write  out  1  load the IR (and OldPC)
pc_write  out  1  load the PC
reg_write  out  1  register-file write enable
result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rd1
alu_src_b  out  2  00 = rd2, 01 = imm, 10 = constant 4
alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J; 00 for unknown op
illegal  out  1  sticky; set on an unknown opcode
instr_done  out  1  one-cycle pulse in the final cycle of each instruction

Behaviour:
- State register
  - 4-bit; reset state FETCH.
  - While resetn is low, all strobes are 0: mem_req, mem_write, ir_write, pc_write, reg_write, instr_done, illegal.
  - Mux selects take the FETCH values during reset.
  - Reset asserted mid-access abandons the access; the state returns to FETCH asynchronously.
- Output style
  - Moore: outputs decode from the state, except ir_write, pc_write and instr_done, which are gated by mem_ready / zero as listed.
  - imm_src is combinational on op in every state.
  - Every output not listed for a state is 0 in that state.
- FETCH
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_write = mem_ready.
  - mem_ready=0: stay in FETCH (wait states, no PC/IR change). mem_ready=1: go to DECODE.
- DECODE
  - alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - other: set illegal, then HALT if ILLEGAL_HALT=1, else FETCH with instr_done=1.
- MEMADR
  - alu_src_a=10, alu_src_b=01, alu_op=00.
  - -> MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD
  - mem_req=1, adr_src=1, result_src=00.
  - Wait for mem_ready, then -> MEMWB.
- MEMWB
  - result_src=01, reg_write=1, instr_done=1.
  - -> FETCH.
- MEMWRITE
  - mem_req=1, mem_write=1, adr_src=1, result_src=00.
  - Held stable through wait states; on mem_ready, instr_done=1 and -> FETCH.
- EXECR
  - alu_src_a=10, alu_src_b=00, alu_op=10.
  - -> ALUWB.
- EXECI
  - alu_src_a=10, alu_src_b=01, alu_op=10.
  - -> ALUWB.
- JAL
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1.
  - -> ALUWB.
- ALUWB
  - result_src=00, reg_write=1, instr_done=1.
  - -> FETCH.
- BEQ
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero; instr_done=1.
  - -> FETCH.
- HALT
  - All strobes 0; stays until reset.
  - illegal stays 1 until resetn is asserted.
- Latency with zero wait states, in cycles:
  - lw 5, sw 4, R 4, I 4, jal 4, beq 3.
  - Each wait state adds one cycle.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants;
  - state enum (FETCH..HALT);
  - encodings for result_src, alu_src_a, alu_src_b, alu_op and imm_src.
- One sub-module, imm_src_dec: combinational op -> imm_src.
- The FSM lives in multicycle_ctrl itself.

Test Plan:
- Reset release, op=0110011, mem_ready=1 -> state sequence FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in cycle 4; instr_done pulses once.
- lw (op=0000011) with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD -> ir_write a single pulse coincident with mem_ready; reg_write with result_src=01 in cycle 10.
- sw (op=0100011) with 1 wait state -> mem_write=1 and adr_src=1 held both MEMWRITE cycles; reg_write never asserted.
- beq with zero=1 and with zero=0 -> pc_write=1 and pc_write=0 respectively in the BEQ cycle; 3 cycles total.
- op=1111111 with ILLEGAL_HALT=1 -> illegal=1 from the cycle after DECODE, no further mem_req; resetn pulse clears illegal and returns to FETCH.
- resetn asserted mid-MEMREAD with mem_ready low -> all strobes drop asynchronously; after release, FETCH with mem_req=1, adr_src=0.
